// File: rtl/axis_traffic_gen_chk.sv
// axis_traffic_gen_chk: AXI-S frame generator (o_axi_s_*, run control i_start/i_stop/i_clr, o_busy/o_done) and checker (i_rx_axis_*) with frame and error counters
module axis_traffic_gen_chk #(
  parameter int P_DATA_WIDTH = 32,
  parameter logic [P_DATA_WIDTH/8-1:0] P_KEEP = '1,
  parameter int P_LEN_W = 16,
  parameter int P_GAP = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_mode,
  input  logic [P_LEN_W-1:0]        i_frame_len,
  input  logic [P_LEN_W-1:0]        i_frame_cnt,
  input  logic                      i_clr,
  output logic [P_DATA_WIDTH-1:0]   o_axi_s_data,
  output logic [P_DATA_WIDTH/8-1:0] o_axi_s_keep,
  output logic                      o_axi_s_last,
  output logic                      o_axi_s_valid,
  input  logic                      i_axi_s_ready,
  input  logic [P_DATA_WIDTH-1:0]   i_rx_axis_data,
  input  logic [P_DATA_WIDTH/8-1:0] i_rx_axis_keep,
  input  logic                      i_rx_axis_last,
  input  logic                      i_rx_axis_valid,
  output logic                      o_rx_axis_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [31:0]               o_tx_frames,
  output logic [31:0]               o_rx_frames,
  output logic [15:0]               o_err_cnt,
  output logic                      o_err
);
  localparam int KW = P_DATA_WIDTH / 8;
  localparam int NR = (P_DATA_WIDTH + 31) / 32;
  localparam logic [P_LEN_W-1:0] ONE = 1;
  localparam logic [15:0] GAP_END = 16'(P_GAP - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_nx;
  logic mode_q, stop_q, tx_last, acc, acc_last, stop_any, run_end;
  logic c_last, c_end, rx_beat, data_bad, rx_bad;
  logic [P_LEN_W-1:0] len_q, idx, sent, c_idx;
  logic [15:0] gap_cnt;
  logic [31:0] lfsr, c_lfsr;
  logic [P_DATA_WIDTH-1:0] c_data;
  logic [KW-1:0] c_keep;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[30] ^ l[27]};
  endfunction

  function automatic logic [P_DATA_WIDTH-1:0] pattern(input logic m, input logic [P_LEN_W-1:0] i, input logic [31:0] l);
    logic [32*NR-1:0] rep;
    rep = {NR{l}};
    return m ? rep[P_DATA_WIDTH-1:0] : P_DATA_WIDTH'(i);
  endfunction

  always_comb begin
    tx_last = idx == len_q - ONE;
    acc = state == SEND && i_axi_s_ready;
    acc_last = acc && tx_last;
    stop_any = stop_q || i_stop;
    run_end = (i_frame_cnt != '0 && sent + ONE == i_frame_cnt) || stop_any;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? (i_start ? SEND : IDLE)
             : state == SEND ? (!acc_last ? SEND : run_end ? IDLE : (P_GAP > 0) ? GAP : SEND)
             : stop_any ? IDLE : gap_cnt == GAP_END ? SEND : GAP;
  end

  always_comb begin
    o_busy = state != IDLE;
    o_axi_s_valid = state == SEND;
    o_axi_s_last = o_axi_s_valid && tx_last;
    o_axi_s_keep = !o_axi_s_valid ? '0 : tx_last ? P_KEEP : '1;
    o_axi_s_data = o_axi_s_valid ? pattern(mode_q, idx, lfsr) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      mode_q <= 1'b0;
      len_q <= ONE;
      idx <= '0;
      lfsr <= 32'd1;
      sent <= '0;
      gap_cnt <= '0;
      stop_q <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= state != IDLE && state_nx == IDLE;
      gap_cnt <= state == GAP ? gap_cnt + 16'd1 : '0;
      if (state == IDLE) begin
        stop_q <= 1'b0;
        if (i_start) begin
          mode_q <= i_mode;
          len_q <= i_frame_len == '0 ? ONE : i_frame_len;
          idx <= '0;
          lfsr <= 32'd1;
          sent <= '0;
        end
      end else begin
        stop_q <= stop_any;
        if (acc) begin
          idx <= acc_last ? '0 : idx + ONE;
          lfsr <= acc_last ? 32'd1 : lfsr_next(lfsr);
        end
        if (acc_last) sent <= sent + ONE;
      end
    end

  // Checker mirrors the generator pattern; any last mismatch (early or missing) restarts its frame.
  always_comb begin
    c_last = c_idx == len_q - ONE;
    c_data = pattern(mode_q, c_idx, c_lfsr);
    c_keep = c_last ? P_KEEP : '1;
    c_end = c_last || i_rx_axis_last;
    rx_beat = i_rx_axis_valid && o_rx_axis_ready;
    data_bad = 1'b0;
    for (int b = 0; b < KW; b++)
      data_bad = data_bad | (i_rx_axis_keep[b] && i_rx_axis_data[8*b +: 8] != c_data[8*b +: 8]);
    rx_bad = rx_beat && (data_bad || i_rx_axis_keep != c_keep || i_rx_axis_last != c_last);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_rx_axis_ready <= 1'b0;
      c_idx <= '0;
      c_lfsr <= 32'd1;
      o_tx_frames <= '0;
      o_rx_frames <= '0;
      o_err_cnt <= '0;
      o_err <= 1'b0;
    end else begin
      o_rx_axis_ready <= 1'b1;
      if (rx_beat) begin
        c_idx <= c_end ? '0 : c_idx + ONE;
        c_lfsr <= c_end ? 32'd1 : lfsr_next(c_lfsr);
      end
      o_tx_frames <= i_clr ? '0 : acc_last ? o_tx_frames + 32'd1 : o_tx_frames;
      o_rx_frames <= i_clr ? '0 : (rx_beat && i_rx_axis_last) ? o_rx_frames + 32'd1 : o_rx_frames;
      o_err_cnt <= i_clr ? '0 : (rx_bad && o_err_cnt != 16'hFFFF) ? o_err_cnt + 16'd1 : o_err_cnt;
      o_err <= !i_clr && (o_err || rx_bad);
    end
endmodule

// File: tb/tb_axis_traffic_gen_chk.sv
// tb_axis_traffic_gen_chk: directed vector bench for axis_traffic_gen_chk (default instance plus P_KEEP=1000/P_GAP=0 instance)
module tb_axis_traffic_gen_chk;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start0 = 0, start1 = 0, stop = 0, mode = 0, clr = 0, ready = 1;
  logic [15:0] flen = 16'd1, fcnt = 16'd1;
  logic inj_en = 0, inj_valid = 0, inj_last = 0;
  logic [31:0] inj_data = 0;
  logic [3:0] inj_keep = 0;
  logic [31:0] d0, d1, tx0, tx1, rx0, rx1, rxd0;
  logic [3:0] k0, k1, rxk0;
  logic l0, l1, v0, v1, rr0, rr1, busy0, busy1, done0, done1, err0, err1, rxl0, rxv0;
  logic [15:0] ec0, ec1;
  assign rxv0 = inj_en ? inj_valid : v0 && ready;
  assign rxd0 = inj_en ? inj_data : d0;
  assign rxk0 = inj_en ? inj_keep : k0;
  assign rxl0 = inj_en ? inj_last : l0;

  axis_traffic_gen_chk u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_stop(stop), .i_mode(mode),
    .i_frame_len(flen), .i_frame_cnt(fcnt), .i_clr(clr),
    .o_axi_s_data(d0), .o_axi_s_keep(k0), .o_axi_s_last(l0), .o_axi_s_valid(v0), .i_axi_s_ready(ready),
    .i_rx_axis_data(rxd0), .i_rx_axis_keep(rxk0), .i_rx_axis_last(rxl0), .i_rx_axis_valid(rxv0),
    .o_rx_axis_ready(rr0), .o_busy(busy0), .o_done(done0), .o_tx_frames(tx0), .o_rx_frames(rx0),
    .o_err_cnt(ec0), .o_err(err0));

  axis_traffic_gen_chk #(.P_KEEP(4'b1000), .P_GAP(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_stop(stop), .i_mode(mode),
    .i_frame_len(flen), .i_frame_cnt(fcnt), .i_clr(clr),
    .o_axi_s_data(d1), .o_axi_s_keep(k1), .o_axi_s_last(l1), .o_axi_s_valid(v1), .i_axi_s_ready(ready),
    .i_rx_axis_data(d1), .i_rx_axis_keep(k1), .i_rx_axis_last(l1), .i_rx_axis_valid(v1 && ready),
    .o_rx_axis_ready(rr1), .o_busy(busy1), .o_done(done1), .o_tx_frames(tx1), .o_rx_frames(rx1),
    .o_err_cnt(ec1), .o_err(err1));

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct {
    logic sel; logic mode; logic [15:0] len; logic [15:0] cnt; int n;
    logic [7:0][31:0] d; logic [7:0][3:0] k; logic [7:0] l; int gi;
  } vec_t;

  int cyc = 0, nvec = 0, nbad = 0, dn0 = 0, dn1 = 0, hold_bad = 0, stall_n = 0;
  beat_t q0[$], q1[$], pb;
  int t0[$], t1[$];
  logic stall_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 && ready) begin q0.push_back({d0, k0, l0}); t0.push_back(cyc); end
    if (v1 && ready) begin q1.push_back({d1, k1, l1}); t1.push_back(cyc); end
    if (done0) dn0++;
    if (done1) dn1++;
    if (stall_prev && (!v0 || {d0, k0, l0} != pb)) hold_bad++;
    if (v0 && !ready) stall_n++;
    stall_prev = v0 && !ready;
    pb = {d0, k0, l0};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
  endtask

  task automatic wait_idle(input logic sel);
    int w = 0;
    while ((sel ? busy1 : busy0) && w < 300) begin @(negedge clk); w++; end
    chk("run_terminates", 32'(w < 300), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_beats0(input int n);
    int w = 0;
    while (q0.size() < n && w < 100) begin @(posedge clk); #1; w++; end
    chk("beats_seen", 32'(q0.size() >= n), 32'd1);
  endtask

  task automatic start_u0(input logic m, input logic [15:0] len, input logic [15:0] cnt);
    mode = m; flen = len; fcnt = cnt;
    q0.delete(); t0.delete(); dn0 = 0;
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0;
  endtask

  vec_t vt[5];
  beat_t ib[17];

  initial begin
    beat_t qq[$];
    int tt[$];
    vt[0] = '{1'b0, 1'b0, 16'd4, 16'd2, 8, {32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0}, {8{4'hF}}, 8'b1000_1000, 4};
    vt[1] = '{1'b1, 1'b0, 16'd1, 16'd2, 2, 256'd0, {24'd0, 4'h8, 4'h8}, 8'b0000_0011, 1};
    vt[2] = '{1'b0, 1'b1, 16'd3, 16'd2, 6, {32'd0, 32'd0, 32'd4, 32'd2, 32'd1, 32'd4, 32'd2, 32'd1}, {8{4'hF}}, 8'b0010_0100, 3};
    vt[3] = '{1'b0, 1'b0, 16'd0, 16'd1, 1, 256'd0, {8{4'hF}}, 8'b0000_0001, -1};
    vt[4] = '{1'b0, 1'b0, 16'd2, 16'd3, 6, {32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0}, {8{4'hF}}, 8'b0010_1010, 2};
    ib = '{{32'd0, 4'hF, 1'b0}, {32'h101, 4'hF, 1'b0}, {32'd2, 4'hF, 1'b0}, {32'd3, 4'hF, 1'b1},
           {32'd0, 4'hF, 1'b1},
           {32'd0, 4'hF, 1'b0}, {32'd1, 4'hF, 1'b0}, {32'd2, 4'hF, 1'b0}, {32'd3, 4'hF, 1'b1},
           {32'd0, 4'hF, 1'b0}, {32'd1, 4'hF, 1'b0}, {32'd2, 4'hF, 1'b0}, {32'd3, 4'hF, 1'b0},
           {32'd0, 4'hF, 1'b0}, {32'd1, 4'hF, 1'b0}, {32'd2, 4'hF, 1'b0}, {32'd3, 4'hF, 1'b1}};

    @(negedge clk);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(rr0), 32'd0);
    chk("rst_data", d0, 32'd0);
    chk("rst_tx", tx0, 32'd0);
    chk("rst_errcnt", 32'(ec0), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rr0), 32'd1);
    chk("ready_after_rst_u1", 32'(rr1), 32'd1);

    for (int i = 0; i < 5; i++) begin
      pulse_clr();
      q0.delete(); q1.delete(); t0.delete(); t1.delete(); dn0 = 0; dn1 = 0;
      mode = vt[i].mode; flen = vt[i].len; fcnt = vt[i].cnt; ready = 1;
      @(posedge clk); #1 if (vt[i].sel) start1 = 1; else start0 = 1;
      @(posedge clk); #1 start0 = 0; start1 = 0;
      @(negedge clk);
      chk("valid_rise", 32'(vt[i].sel ? v1 : v0), 32'd1);
      chk("busy_rise", 32'(vt[i].sel ? busy1 : busy0), 32'd1);
      wait_idle(vt[i].sel);
      if (vt[i].sel) begin qq = q1; tt = t1; end else begin qq = q0; tt = t0; end
      chk("beat_count", 32'(qq.size()), 32'(vt[i].n));
      for (int j = 0; j < vt[i].n && j < qq.size(); j++) begin
        chk("data", qq[j].d, vt[i].d[j]);
        chk("keep", 32'(qq[j].k), 32'(vt[i].k[j]));
        chk("last", 32'(qq[j].l), 32'(vt[i].l[j]));
      end
      if (vt[i].gi > 0 && tt.size() > vt[i].gi)
        chk("frame_spacing", 32'(tt[vt[i].gi] - tt[vt[i].gi - 1]), vt[i].sel ? 32'd1 : 32'd5);
      chk("done_pulses", 32'(vt[i].sel ? dn1 : dn0), 32'd1);
      chk("tx_frames", vt[i].sel ? tx1 : tx0, 32'(vt[i].cnt));
      chk("rx_frames", vt[i].sel ? rx1 : rx0, 32'(vt[i].cnt));
      chk("err_cnt", 32'(vt[i].sel ? ec1 : ec0), 32'd0);
    end

    pulse_clr();
    hold_bad = 0; stall_n = 0;
    start_u0(1'b0, 16'd4, 16'd1);
    wait_beats0(2);
    ready = 0;
    repeat (3) @(posedge clk);
    #1 ready = 1;
    wait_idle(1'b0);
    chk("stall_cycles", 32'(stall_n), 32'd3);
    chk("stall_hold", 32'(hold_bad), 32'd0);
    chk("stall_beats", 32'(q0.size()), 32'd4);
    for (int j = 0; j < 4 && j < q0.size(); j++) chk("stall_data", q0[j].d, 32'(j));
    chk("stall_errs", 32'(ec0), 32'd0);
    chk("stall_rx", rx0, 32'd1);

    pulse_clr();
    inj_en = 1;
    for (int j = 0; j < 17; j++) begin
      @(posedge clk); #1 inj_valid = 1; inj_data = ib[j].d; inj_keep = ib[j].k; inj_last = ib[j].l;
      if (j == 9) begin
        @(negedge clk);
        chk("inj_errcnt", 32'(ec0), 32'd2);
        chk("inj_err", 32'(err0), 32'd1);
        chk("inj_rx", rx0, 32'd3);
      end
    end
    @(posedge clk); #1 inj_valid = 0;
    @(negedge clk);
    chk("missing_last_errcnt", 32'(ec0), 32'd3);
    chk("resync_rx", rx0, 32'd4);
    @(posedge clk); #1 inj_valid = 1; inj_data = 32'd0; inj_keep = 4'hF; inj_last = 1; clr = 1;
    @(posedge clk); #1 inj_valid = 0; clr = 0;
    @(negedge clk);
    chk("clr_errcnt", 32'(ec0), 32'd0);
    chk("clr_err", 32'(err0), 32'd0);
    chk("clr_rx", rx0, 32'd0);
    chk("clr_tx", tx0, 32'd0);
    inj_en = 0;

    start_u0(1'b0, 16'd4, 16'd0);
    wait_beats0(2);
    stop = 1;
    @(posedge clk); #1 stop = 0;
    wait_idle(1'b0);
    chk("stop_beats", 32'(q0.size()), 32'd4);
    if (q0.size() >= 4) chk("stop_last", 32'(q0[3].l), 32'd1);
    chk("stop_done", 32'(dn0), 32'd1);
    chk("stop_tx", tx0, 32'd1);
    chk("stop_busy", 32'(busy0), 32'd0);

    start_u0(1'b0, 16'd4, 16'd0);
    wait_beats0(2);
    rst_n = 0;
    #1;
    chk("abort_valid", 32'(v0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_data", d0, 32'd0);
    chk("abort_keep", 32'(k0), 32'd0);
    chk("abort_last", 32'(l0), 32'd0);
    chk("abort_ready", 32'(rr0), 32'd0);
    chk("abort_tx", tx0, 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("abort_ready_back", 32'(rr0), 32'd1);
    chk("abort_no_done", 32'(dn0), 32'd0);
    chk("abort_idle", 32'(busy0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
